tri_bus_arbiter: RTL and testbench

//   Round-robin arbiter and output-enable sequencer for a shared tri-state bus
//   (tri/tri0 net) with N candidate drivers. Grants one owner at a time, forces

---
 rtl/tri_bus_arbiter.sv | 143 ++++++++++++++
 tb/tb_tri_bus_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/tri_bus_arbiter.sv
// tri_bus_arbiter
//   Round-robin arbiter and output-enable sequencer for a shared tri-state bus.
//   It grants one driver at a time and forces a release after MAX_HOLD grant
//   cycles. After every tenure it inserts TURNAROUND cycles with all enables
//   low, so two drivers never overlap on the net.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous reset, active-high; drops every enable at once
//   req[N]    level request, bit k = requester k
//   done[N]   early-release pulse; only the current owner's bit is used
//   gnt[N]    one-hot grant (registered)
//   oe[N]     one-hot tri-state enable (registered, always equal to gnt)
//   owner     index of the current owner, or of the last owner when idle
//   bus_busy  high while any gnt bit is high
//   preempt   1-cycle pulse when the hold limit forces a release
module tri_bus_arbiter #(
    parameter int N          = 4,
    parameter int MAX_HOLD   = 8,
    parameter int TURNAROUND = 1,
    localparam int ID_W      = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    done,
    output logic [N-1:0]    gnt,
    output logic [N-1:0]    oe,
    output logic [ID_W-1:0] owner,
    output logic            bus_busy,
    output logic            preempt
);

    localparam int HC_W = $clog2(MAX_HOLD + 1);
    localparam int TC_W = $clog2(TURNAROUND + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    state_t          state;
    logic [HC_W-1:0] hold_cnt;
    logic [TC_W-1:0] turn_cnt;
    logic [ID_W-1:0] rr_ptr;

    logic            pick_vld;
    logic [ID_W-1:0] pick_id;
    logic            hold_max;
    logic            turn_last;
    logic            own_req;
    logic            own_done;
    logic            release_now;
    logic            do_grant;
    logic [ID_W-1:0] nxt_ptr;

    // Round-robin pick: scan downwards from the farthest offset so that the
    // last match written is the first set bit at or after rr_ptr.
    always_comb begin
        int idx;
        idx      = 0;
        pick_vld = 1'b0;
        pick_id  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = (int'(rr_ptr) + i) % N;
            if (req[idx]) begin
                pick_vld = 1'b1;
                pick_id  = ID_W'(idx);
            end
        end
    end

    always_comb begin
        hold_max    = (hold_cnt == HC_W'(MAX_HOLD));
        turn_last   = (turn_cnt == TC_W'(TURNAROUND));
        own_req     = req[owner];
        own_done    = done[owner];
        release_now = !own_req || own_done || hold_max;
        // Arbitration happens in IDLE and on the final turnaround cycle only.
        do_grant    = pick_vld && ((state == IDLE) || ((state == TURN) && turn_last));
        // The releasing owner becomes the lowest priority for the next pick.
        nxt_ptr     = (owner == ID_W'(N - 1)) ? '0 : owner + ID_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            oe       <= '0;
            owner    <= '0;
            bus_busy <= 1'b0;
            preempt  <= 1'b0;
            hold_cnt <= '0;
            turn_cnt <= '0;
            rr_ptr   <= '0;
        end else begin
            preempt <= 1'b0;
            if (do_grant) begin
                state    <= GRANT;
                gnt      <= {{(N-1){1'b0}}, 1'b1} << pick_id;
                oe       <= {{(N-1){1'b0}}, 1'b1} << pick_id;
                owner    <= pick_id;
                bus_busy <= 1'b1;
                hold_cnt <= HC_W'(1);
            end else begin
                case (state)
                    IDLE: begin
                        gnt      <= '0;
                        oe       <= '0;
                        bus_busy <= 1'b0;
                    end
                    GRANT: begin
                        if (release_now) begin
                            state    <= TURN;
                            gnt      <= '0;
                            oe       <= '0;
                            bus_busy <= 1'b0;
                            rr_ptr   <= nxt_ptr;
                            turn_cnt <= TC_W'(1);
                            // Only a forced release of a still-requesting,
                            // not-finishing owner counts as preemption.
                            preempt  <= hold_max && own_req && !own_done;
                        end else if (!hold_max) begin
                            hold_cnt <= hold_cnt + HC_W'(1);
                        end
                    end
                    TURN: begin
                        if (turn_last) state <= IDLE;
                        else           turn_cnt <= turn_cnt + TC_W'(1);
                    end
                    default: begin
                        state    <= IDLE;
                        gnt      <= '0;
                        oe       <= '0;
                        bus_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tri_bus_arbiter.sv
module tb_tri_bus_arbiter;

    localparam int N_B   = 5;
    localparam int MH_B  = 3;
    localparam int TA_B  = 2;
    localparam int BOUND = (N_B - 1) * (MH_B + TA_B) + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: default parameters, directed tests
    logic       rst_a = 1'b0;
    logic [3:0] req_a = '0, done_a = '0, gnt_a, oe_a;
    logic [1:0] owner_a;
    logic       busy_a, pre_a;

    // DUT B: N=5, TURNAROUND=2, random test against the model
    logic           rst_b = 1'b1;
    logic [N_B-1:0] req_b = '0, done_b = '0, gnt_b, oe_b;
    logic [2:0]     owner_b;
    logic           busy_b, pre_b;

    tri_bus_arbiter u_a (
        .clk(clk), .rst(rst_a), .req(req_a), .done(done_a),
        .gnt(gnt_a), .oe(oe_a), .owner(owner_a), .bus_busy(busy_a), .preempt(pre_a)
    );

    tri_bus_arbiter #(.N(N_B), .MAX_HOLD(MH_B), .TURNAROUND(TA_B)) u_b (
        .clk(clk), .rst(rst_b), .req(req_b), .done(done_b),
        .gnt(gnt_b), .oe(oe_b), .owner(owner_b), .bus_busy(busy_b), .preempt(pre_b)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0] req;
        logic [3:0] done;
        logic [3:0] gnt;
        logic [1:0] owner;
        logic       pre;
    } vec_t;
    vec_t tbl[$];

    task automatic tick_a();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_a();
        req_a  = '0;
        done_a = '0;
        @(negedge clk);
        rst_a = 1'b1;
        #2;
        rst_a = 1'b0;
    endtask

    task automatic chk_a(input string name, input logic [3:0] g, input logic [1:0] o, input logic p);
        chk(name, {gnt_a, oe_a, owner_a, busy_a, pre_a}, {g, g, o, (g != 4'b0), p});
    endtask

    // Tenure-level reference: who owns the bus, how long, and how many
    // all-off cycles remain before the next pick.
    int m_cur, m_ten, m_gap, m_ptr, m_owner;
    logic m_pre;

    task automatic model_reset();
        m_cur = -1; m_ten = 0; m_gap = 0; m_ptr = 0; m_owner = 0; m_pre = 1'b0;
    endtask

    task automatic model_edge(input logic [N_B-1:0] r, input logic [N_B-1:0] d);
        m_pre = 1'b0;
        if (m_cur >= 0) begin
            if (!r[m_cur] || d[m_cur] || m_ten == MH_B) begin
                m_pre = (m_ten == MH_B) && r[m_cur] && !d[m_cur];
                m_ptr = (m_cur + 1) % N_B;
                m_cur = -1;
                m_gap = TA_B;
            end else begin
                m_ten++;
            end
        end else begin
            if (m_gap > 0) m_gap--;
            if (m_gap == 0 && r != '0) begin
                for (int i = 0; i < N_B; i++) begin
                    if (m_cur < 0 && r[(m_ptr + i) % N_B]) m_cur = (m_ptr + i) % N_B;
                end
                m_owner = m_cur;
                m_ten   = 1;
            end
        end
    endtask

    initial begin
        logic [N_B-1:0] exp_g;
        int off_run, maxw;
        logic had_owner;
        logic [N_B-1:0] prev_g;
        int waitc[N_B];

        // ---------------- reset state ----------------
        reset_a();
        #1;
        chk_a("reset_state", 4'b0, 2'd0, 1'b0);

        // ---------------- table: single owner + early release ----------------
        tbl.push_back('{4'h1, 4'h0, 4'h1, 2'd0, 1'b0});
        tbl.push_back('{4'h1, 4'h0, 4'h1, 2'd0, 1'b0});
        tbl.push_back('{4'h1, 4'h0, 4'h1, 2'd0, 1'b0});
        tbl.push_back('{4'h0, 4'h0, 4'h0, 2'd0, 1'b0});
        tbl.push_back('{4'h0, 4'h0, 4'h0, 2'd0, 1'b0});
        tbl.push_back('{4'h4, 4'h0, 4'h4, 2'd2, 1'b0});
        tbl.push_back('{4'hd, 4'h0, 4'h4, 2'd2, 1'b0});
        tbl.push_back('{4'hd, 4'h4, 4'h0, 2'd2, 1'b0});
        tbl.push_back('{4'hd, 4'h0, 4'h8, 2'd3, 1'b0});
        tbl.push_back('{4'h5, 4'h0, 4'h0, 2'd3, 1'b0});
        tbl.push_back('{4'h5, 4'h0, 4'h1, 2'd0, 1'b0});
        tbl.push_back('{4'h5, 4'h1, 4'h0, 2'd0, 1'b0});
        tbl.push_back('{4'h4, 4'h0, 4'h4, 2'd2, 1'b0});
        tbl.push_back('{4'h0, 4'h0, 4'h0, 2'd2, 1'b0});
        tbl.push_back('{4'h0, 4'h0, 4'h0, 2'd2, 1'b0});
        foreach (tbl[i]) begin
            req_a  = tbl[i].req;
            done_a = tbl[i].done;
            tick_a();
            chk_a($sformatf("tbl_%0d", i), tbl[i].gnt, tbl[i].owner, tbl[i].pre);
        end

        // ---------------- all requesting: forced rotation ----------------
        reset_a();
        req_a = 4'hf;
        for (int tn = 0; tn < 5; tn++) begin
            for (int c = 0; c < 8; c++) begin
                tick_a();
                chk_a($sformatf("rot_t%0d_c%0d", tn, c), 4'b1 << (tn % 4), 2'(tn % 4), 1'b0);
            end
            tick_a();
            chk_a($sformatf("rot_t%0d_off", tn), 4'b0, 2'(tn % 4), 1'b1);
        end
        req_a = 4'h0;
        tick_a();
        chk_a("rot_idle", 4'b0, 2'd0, 1'b0);

        // ---------------- single requester re-granted every tenure ----------------
        reset_a();
        req_a = 4'h2;
        for (int tn = 0; tn < 3; tn++) begin
            for (int c = 0; c < 8; c++) begin
                tick_a();
                chk_a($sformatf("solo_t%0d_c%0d", tn, c), 4'h2, 2'd1, 1'b0);
            end
            tick_a();
            chk_a($sformatf("solo_t%0d_off", tn), 4'b0, 2'd1, 1'b1);
        end

        // ---------------- async reset mid-grant ----------------
        tick_a();
        tick_a();
        chk_a("pre_rst_grant", 4'h2, 2'd1, 1'b0);
        #3;
        rst_a = 1'b1;
        #1;
        chk_a("async_rst_drop", 4'b0, 2'd0, 1'b0);
        req_a = 4'h4;
        #2;
        rst_a = 1'b0;
        tick_a();
        chk_a("post_rst_grant", 4'h4, 2'd2, 1'b0);
        req_a = 4'h0;

        // ---------------- random run on DUT B against the model ----------------
        model_reset();
        @(negedge clk);
        #2;
        rst_b = 1'b0;
        off_run = 0; had_owner = 1'b0; prev_g = '0;
        for (int k = 0; k < N_B; k++) waitc[k] = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int k = 0; k < N_B; k++) begin
                if ($urandom_range(0, 7) == 0) req_b[k] = ~req_b[k];
                done_b[k] = ($urandom_range(0, 7) == 0);
            end
            @(posedge clk);
            model_edge(req_b, done_b);
            #1;
            exp_g = (m_cur >= 0) ? (N_B'(1) << m_cur) : '0;
            chk("rnd_model", {gnt_b, oe_b, owner_b, busy_b, pre_b},
                {exp_g, exp_g, 3'(m_owner), (exp_g != '0), m_pre});
            chk("rnd_onehot0", $onehot0(oe_b), 1);
            if (gnt_b == '0) begin
                off_run++;
            end else begin
                if (gnt_b != prev_g && had_owner) chk("rnd_gap", off_run >= TA_B, 1);
                had_owner = 1'b1;
                off_run = 0;
            end
            prev_g = gnt_b;
            maxw = 0;
            for (int k = 0; k < N_B; k++) begin
                if (req_b[k] && !gnt_b[k]) waitc[k]++;
                else waitc[k] = 0;
                if (waitc[k] > maxw) maxw = waitc[k];
            end
            chk("rnd_starve", maxw <= BOUND, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
